program_fetch_sequencer: RTL
============================

// Module: program_fetch_sequencer
// PURPOSE
//  Sequences the combinational program ROM: owns the PC, drives the ROM byte address,
//  registers each returned word into a one-entry output buffer, and hands it to decode
//  with a valid/ready handshake. Supports start/halt, branch/jump redirect, and a
//  sticky fault on misaligned or out-of-range PCs. Sits between the ROM and the decode stage.
// PARAMETERS
//  DATA_WIDTH    32  width of address, PC and instruction words
//  MEMORY_DEPTH  32  ROM depth in words; legal PC word index is 0..MEMORY_DEPTH-1
//  RESET_PC      0   PC value after reset (byte address, word aligned)
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           synchronous, active-low reset
//  start_i        in   1           pulse: begin/resume fetching (IDLE/HALT -> FETCH)
//  halt_i         in   1           level: stop issuing new fetches (FETCH -> HALT)
//  redirect_i     in   1           pulse: load PC from redirect_pc_i, flush buffer
//  redirect_pc_i  in   DATA_WIDTH  redirect target byte address
//  rom_addr_o     out  DATA_WIDTH  byte address to ROM (= current PC)
//  rom_instr_i    in   DATA_WIDTH  ROM word at rom_addr_o, same cycle (combinational)
//  instr_o        out  DATA_WIDTH  buffered instruction
//  instr_pc_o     out  DATA_WIDTH  byte address of instr_o
//  instr_valid_o  out  1           instr_o/instr_pc_o valid
//  instr_ready_i  in   1           decode accepts when valid && ready on a rising edge
//  busy_o         out  1           1 when state == FETCH
//  fault_o        out  1           sticky fault flag
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, PC=RESET_PC, instr_o=0, instr_pc_o=0,
//   instr_valid_o=0, busy_o=0, fault_o=0. Reset wins over all inputs, mid-operation too.
//  rom_addr_o = PC continuously. Word index = PC[DATA_WIDTH-1:2].
//  States: IDLE, FETCH, HALT, FAULT (2-bit encoding).
//  Issue slot: state==FETCH && !halt_i && !redirect_i && (!instr_valid_o || instr_ready_i).
//   If PC word index < MEMORY_DEPTH: instr_o<=rom_instr_i, instr_pc_o<=PC,
//   instr_valid_o<=1, PC<=PC+4 (modulo 2^DATA_WIDTH). Latency: PC to instr_o is 1 cycle.
//   Otherwise: state<=FAULT, fault_o<=1, instr_valid_o<=0, PC unchanged.
//  No issue slot and no redirect: buffer holds. If valid && ready, instr_valid_o<=0;
//   else valid data and PC hold stable (stall).
//  Throughput: 1 instruction/cycle while instr_ready_i==1.
//  Redirect (IDLE/FETCH/HALT): instr_valid_o<=0 (pending entry discarded even if ready=1).
//   If redirect_pc_i[1:0]!=0: state<=FAULT, fault_o<=1, PC unchanged. Else PC<=redirect_pc_i
//   and state is unchanged (subject to halt below). Issue resumes the next cycle.
//  Transitions: IDLE --start_i&&!halt_i--> FETCH; FETCH --halt_i--> HALT;
//   HALT --start_i&&!halt_i--> FETCH; FETCH --out-of-range issue--> FAULT;
//   any non-FAULT --misaligned redirect--> FAULT; FAULT left only by reset.
//  HALT/IDLE: no new issue; a pending valid entry still drains on ready.
//  Simultaneous events: halt_i beats start_i; redirect_i+halt_i -> PC loaded,
//   buffer flushed, state HALT. FAULT ignores start/halt/redirect; outputs hold, valid=0.
//  Wrap-around: PC+4 overflow wraps to 0 and is caught by the range check when
//   MEMORY_DEPTH < 2^(DATA_WIDTH-2).
// CONFIGURATION
//  FETCH_PERF_COUNTERS_EN defined: adds outputs fetch_count_o[31:0] (+1 per issue) and
//   stall_count_o[31:0] (+1 per FETCH cycle with instr_valid_o && !instr_ready_i); both
//   reset to 0, wrap at 2^32, freeze in FAULT. Undefined: ports and logic absent; all
//   other behaviour identical.
// TESTING
//  Reset, start, ready=1, ROM[i]=i+0x100 -> instr_o 0x100,0x101,0x102 on consecutive
//   cycles; instr_pc_o 0,4,8; busy_o=1.
//  Ready low 3 cycles while valid -> instr_o, instr_pc_o, rom_addr_o stable; resume
//   without loss or duplication.
//  Redirect to 0x10 while valid && !ready -> next cycle valid=0; following cycle
//   instr_pc_o=0x10, instr_o=ROM[4].
//  Redirect to 0x06 -> fault_o=1, valid=0; later start/redirect ignored until reset.
//  MEMORY_DEPTH=4, run from 0 -> 4 instructions issued, then fault_o=1 at PC=0x10.
//  Halt+start same cycle in FETCH -> HALT; reset low mid-run -> all outputs at reset values.

Source files
------------

// File: rtl/program_fetch_sequencer_if.sv
// program_fetch_sequencer_if: control, ROM and decode-side signals of the fetch sequencer.
interface program_fetch_sequencer_if #(parameter int DATA_WIDTH = 32);
  logic                  start_i;
  logic                  halt_i;
  logic                  redirect_i;
  logic [DATA_WIDTH-1:0] redirect_pc_i;
  logic [DATA_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_instr_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [DATA_WIDTH-1:0] instr_pc_o;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic                  busy_o;
  logic                  fault_o;
  modport master (
    input  start_i, halt_i, redirect_i, redirect_pc_i, rom_instr_i, instr_ready_i,
    output rom_addr_o, instr_o, instr_pc_o, instr_valid_o, busy_o, fault_o
  );
  modport slave (
    output start_i, halt_i, redirect_i, redirect_pc_i, rom_instr_i, instr_ready_i,
    input  rom_addr_o, instr_o, instr_pc_o, instr_valid_o, busy_o, fault_o
  );
endinterface

// File: rtl/program_fetch_sequencer.sv
// program_fetch_sequencer: owns the PC, buffers one ROM word for decode, sticky fault on bad PCs.
// Optional FETCH_PERF_COUNTERS_EN adds fetch_count_o / stall_count_o.
module program_fetch_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  program_fetch_sequencer_if.master bus
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]              fetch_count_o,
  output logic [31:0]              stall_count_o
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, HALT, FAULT} state_t;
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_pc, r_instr, r_instr_pc;
  logic                  r_valid;
  logic                  w_slot, w_in_range, w_misaligned;
  assign w_in_range   = {2'b00, r_pc[DATA_WIDTH-1:2]} < DATA_WIDTH'(MEMORY_DEPTH);
  assign w_misaligned = bus.redirect_pc_i[1:0] != 2'b00;
  assign w_slot       = r_state == FETCH && !bus.halt_i && !bus.redirect_i && (!r_valid || bus.instr_ready_i);
  always_comb begin
    w_next = r_state;
    if (r_state != FAULT) begin
      if (bus.redirect_i && w_misaligned) w_next = FAULT;
      else if (r_state == FETCH && bus.halt_i) w_next = HALT;
      else if (w_slot && !w_in_range) w_next = FAULT;
      else if (r_state != FETCH && !bus.redirect_i && bus.start_i && !bus.halt_i) w_next = FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FAULT) begin
        r_valid <= 1'b0;
      end else if (bus.redirect_i) begin
        r_valid <= 1'b0;
        if (!w_misaligned) r_pc <= bus.redirect_pc_i;
      end else if (w_slot) begin
        r_valid <= w_in_range;
        if (w_in_range) begin
          r_instr    <= bus.rom_instr_i;
          r_instr_pc <= r_pc;
          r_pc       <= r_pc + DATA_WIDTH'(4);
        end
      end else if (r_valid && bus.instr_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end
`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      if (w_slot && w_in_range) fetch_count_o <= fetch_count_o + 32'd1;
      if (r_state == FETCH && r_valid && !bus.instr_ready_i) stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif
  assign bus.rom_addr_o    = r_pc;
  assign bus.instr_o       = r_instr;
  assign bus.instr_pc_o    = r_instr_pc;
  assign bus.instr_valid_o = r_valid;
  assign bus.busy_o        = r_state == FETCH;
  assign bus.fault_o       = r_state == FAULT;
endmodule
